// File: rtl/conv1_requant_relu_maxpool.sv
// conv1 stem post-processing: requantize (shift, ReLU, saturate) then 3x3/s2/p1 max-pool.
// Define CONV1_REQUANT_ROUND_EN for round-half-up requant; default build floors.
module conv1_requant_relu_maxpool #(
  parameter int DATA_W_P  = 8,
  parameter int ACC_W_P   = 32,
  parameter int C_P       = 64,
  parameter int H_P       = 56,
  parameter int W_P       = 56,
  parameter int SHIFT_W_P = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [SHIFT_W_P-1:0] shift_i,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_W_P-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W_P-1:0]  out_data,
  output logic                 busy,
  output logic                 done
);
  localparam int OWN = W_P / 2;
  localparam int CW  = (C_P > 1) ? $clog2(C_P) : 1;
  localparam int HW  = (H_P > 1) ? $clog2(H_P) : 1;
  localparam int WW  = (W_P > 1) ? $clog2(W_P) : 1;
  localparam int OWW = (OWN > 1) ? $clog2(OWN) : 1;
  localparam logic signed [ACC_W_P:0] QMAX = (ACC_W_P+1)'(2**(DATA_W_P-1) - 1);

  typedef logic [DATA_W_P-1:0] elem_t;

  logic                 busy_q, busy_d;
  logic                 in_done_q, in_done_d;
  logic                 fin_pend_q, fin_pend_d;
  logic                 done_q, done_d;
  logic [SHIFT_W_P-1:0] shift_q, shift_d;
  logic [CW-1:0]        c_q, c_d;
  logic [HW-1:0]        h_q, h_d;
  logic [WW-1:0]        w_q, w_d;
  elem_t                carry_q, carry_d;
  elem_t                hacc_q, hacc_d;
  logic [OWN-1:0][DATA_W_P-1:0] prev_q, prev_d;
  logic [OWN-1:0][DATA_W_P-1:0] cur_q, cur_d;
  logic                 out_valid_q, out_valid_d;
  elem_t                out_data_q, out_data_d;

  logic signed [ACC_W_P:0] acc_x, sum, q;
  logic [ACC_W_P:0]        rnd;
  elem_t                   r, hl, hm, pooled;
  logic [OWW-1:0]          ow;
  logic                    accept, out_fire;

  function automatic elem_t mx(input elem_t a, input elem_t b);
    return (a > b) ? a : b;
  endfunction

  assign in_ready  = busy_q && !in_done_q && (!out_valid_q || out_ready);
  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

  // Requant in ACC_W_P+1 bits so the rounding add can never overflow.
  always_comb begin
    acc_x = {in_data[ACC_W_P-1], in_data};
`ifdef CONV1_REQUANT_ROUND_EN
    rnd = ((ACC_W_P+1)'(1) << shift_q) >> 1;
`else
    rnd = '0;
`endif
    sum = acc_x + $signed(rnd);
    q   = sum >>> shift_q;
    if (q[ACC_W_P])  r = '0;
    else if (q > QMAX) r = QMAX[DATA_W_P-1:0];
    else             r = q[DATA_W_P-1:0];
  end

  // Left pad column and pad rows read as 0, exact since r >= 0.
  always_comb begin
    ow     = OWW'(w_q >> 1);
    hl     = (w_q == '0) ? '0 : carry_q;
    hm     = mx(hacc_q, r);
    pooled = mx(mx(prev_q[ow], cur_q[ow]), hm);
  end

  always_comb begin
    busy_d      = busy_q;
    in_done_d   = in_done_q;
    fin_pend_d  = fin_pend_q;
    done_d      = 1'b0;
    shift_d     = shift_q;
    c_d         = c_q;
    h_d         = h_q;
    w_d         = w_q;
    carry_d     = carry_q;
    hacc_d      = hacc_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (!busy_q) begin
      if (start) begin
        busy_d     = 1'b1;
        in_done_d  = 1'b0;
        fin_pend_d = 1'b0;
        shift_d    = shift_i;
        c_d        = '0;
        h_d        = '0;
        w_d        = '0;
        carry_d    = '0;
        hacc_d     = '0;
        prev_d     = '0;
        cur_d      = '0;
      end
    end else begin
      if (out_fire) begin
        out_valid_d = 1'b0;
        if (fin_pend_q) begin
          fin_pend_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end
      end
      if (accept) begin
        if (!w_q[0]) begin
          hacc_d = mx(hl, r);
        end else begin
          carry_d = r;
          // Odd-row maxima become the top tap row of the next output row.
          if (!h_q[0]) cur_d[ow]  = hm;
          else         prev_d[ow] = hm;
          if (h_q[0]) begin
            out_valid_d = 1'b1;
            out_data_d  = pooled;
          end
        end
        if (w_q == WW'(W_P-1)) begin
          w_d = '0;
          if (h_q == HW'(H_P-1)) begin
            h_d    = '0;
            prev_d = '0;
            cur_d  = '0;
            if (c_q == CW'(C_P-1)) begin
              in_done_d  = 1'b1;
              fin_pend_d = 1'b1;
            end else begin
              c_d = c_q + CW'(1);
            end
          end else begin
            h_d = h_q + HW'(1);
          end
        end else begin
          w_d = w_q + WW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      in_done_q   <= 1'b0;
      fin_pend_q  <= 1'b0;
      done_q      <= 1'b0;
      shift_q     <= '0;
      c_q         <= '0;
      h_q         <= '0;
      w_q         <= '0;
      carry_q     <= '0;
      hacc_q      <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      busy_q      <= busy_d;
      in_done_q   <= in_done_d;
      fin_pend_q  <= fin_pend_d;
      done_q      <= done_d;
      shift_q     <= shift_d;
      c_q         <= c_d;
      h_q         <= h_d;
      w_q         <= w_d;
      carry_q     <= carry_d;
      hacc_q      <= hacc_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
endmodule
